// File: rtl/register_bank.sv
// register_bank: small CPU-style register file with instruction register, program counter,
// general registers with two combinational read ports, an output register with a
// valid/ack handshake and sticky overrun status, and carry/zero flags.
//
// Optional feature macro: REGISTER_BANK_ZERO_FLAG_EN
//   defined   -> flag_zero latches (dbus == 0) on assert_e
//   undefined -> o_flag_zero is tied to 0
//
// Ports:
//   i_clk                   rising-edge clock for all state
//   i_reset                 synchronous active-high reset, overrides all other inputs
//   i_load_ir               capture i_dbus into ir (ir clears otherwise)
//   i_load_pc, i_jump       both high: pc <= i_abus
//   i_immediate             pc increment request (lower priority than jump)
//   i_load_en, i_load_sel   write i_dbus to general register i_load_sel
//   i_do_out, i_q_ack       output register load / consumer acknowledge
//   i_assert_e, i_carry     flag update strobe and carry-in
//   i_dbus, i_abus          data and address buses
//   i_rd_a_sel, i_rd_b_sel  read-port selects
//   o_ir, o_pc, o_qreg      registered state
//   o_rd_a, o_rd_b          combinational reads (0 for selects >= NREG)
//   o_q_valid, o_q_overrun  output handshake status
//   o_flag_carry, o_flag_zero  registered flags
module register_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREG  = 4,
   // Must be at least ceil(log2(NREG)).
   parameter int unsigned SELW  = 2
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_load_ir,
   input  logic             i_load_pc,
   input  logic             i_jump,
   input  logic             i_immediate,
   input  logic             i_load_en,
   input  logic [SELW-1:0]  i_load_sel,
   input  logic             i_do_out,
   input  logic             i_q_ack,
   input  logic             i_assert_e,
   input  logic             i_carry,
   input  logic [WIDTH-1:0] i_dbus,
   input  logic [WIDTH-1:0] i_abus,
   input  logic [SELW-1:0]  i_rd_a_sel,
   input  logic [SELW-1:0]  i_rd_b_sel,
   output logic [WIDTH-1:0] o_ir,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_qreg,
   output logic [WIDTH-1:0] o_rd_a,
   output logic [WIDTH-1:0] o_rd_b,
   output logic             o_q_valid,
   output logic             o_q_overrun,
   output logic             o_flag_carry,
   output logic             o_flag_zero
);

   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_qreg;
   logic [WIDTH-1:0] r_gpr [NREG];
   logic             r_q_valid;
   logic             r_q_overrun;
   logic             r_flag_carry;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ir         <= '0;
         r_pc         <= '0;
         r_qreg       <= '0;
         r_q_valid    <= 1'b0;
         r_q_overrun  <= 1'b0;
         r_flag_carry <= 1'b0;
         for (int unsigned k = 0; k < NREG; k++) begin
            r_gpr[k] <= '0;
         end
      end else begin
         r_ir <= i_load_ir ? i_dbus : '0;

         if (i_load_pc && i_jump) begin
            r_pc <= i_abus;
         end else if (i_immediate) begin
            r_pc <= r_pc + WIDTH'(1);
         end

         // Selects that match no register (>= NREG) simply write nothing.
         for (int unsigned k = 0; k < NREG; k++) begin
            if (i_load_en && (i_load_sel == SELW'(k))) begin
               r_gpr[k] <= i_dbus;
            end
         end

         if (i_do_out) begin
            r_qreg    <= i_dbus;
            r_q_valid <= 1'b1;
            // A simultaneous ack consumes the old value, so that is not an overrun.
            if (r_q_valid && !i_q_ack) begin
               r_q_overrun <= 1'b1;
            end
         end else if (i_q_ack) begin
            r_q_valid <= 1'b0;
         end

         if (i_assert_e) begin
            r_flag_carry <= i_carry;
         end
      end
   end

`ifdef REGISTER_BANK_ZERO_FLAG_EN
   logic r_flag_zero;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_flag_zero <= 1'b0;
      end else if (i_assert_e) begin
         r_flag_zero <= (i_dbus == '0);
      end
   end

   assign o_flag_zero = r_flag_zero;
`else
   assign o_flag_zero = 1'b0;
`endif

   // Reads see registered contents only; a same-cycle write is not bypassed.
   always_comb begin
      o_rd_a = '0;
      o_rd_b = '0;
      for (int unsigned k = 0; k < NREG; k++) begin
         if (i_rd_a_sel == SELW'(k)) begin
            o_rd_a = r_gpr[k];
         end
         if (i_rd_b_sel == SELW'(k)) begin
            o_rd_b = r_gpr[k];
         end
      end
   end

   assign o_ir         = r_ir;
   assign o_pc         = r_pc;
   assign o_qreg       = r_qreg;
   assign o_q_valid    = r_q_valid;
   assign o_q_overrun  = r_q_overrun;
   assign o_flag_carry = r_flag_carry;

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width of all registers and buses.
REQ-002 SHALL have parameter NREG, default 4, number of general registers (2..16).
REQ-003 SHALL have parameter SELW, default 2, register-select width; SELW SHALL be at least ceil(log2(NREG)).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_ir  input  1  capture dbus into ir, else ir clears.
REQ-007 load_pc, jump  input  1 each  pc <= abus when both are high.
REQ-008 immediate  input  1  pc increment request.
REQ-009 load_en, load_sel  input  1, SELW  write dbus to general register load_sel.
REQ-010 do_out  input  1  capture dbus into qreg.
REQ-011 q_ack  input  1  consumer accepts qreg.
REQ-012 assert_e, carry  input  1 each  flag update strobe and carry-in.
REQ-013 dbus, abus  input  WIDTH each  data bus and address bus.
REQ-014 rd_a_sel, rd_b_sel  input  SELW each  read-port selects.
REQ-015 ir, pc, qreg  output  WIDTH each  registered state.
REQ-016 rd_a, rd_b  output  WIDTH each  combinational read of selected general register.
REQ-017 q_valid, q_overrun  output  1 each  output handshake status.
REQ-018 flag_carry, flag_zero  output  1 each  registered flags.

Function
REQ-019 ir SHALL load dbus when load_ir=1 and SHALL load 0 on every other cycle.
REQ-020 pc priority SHALL be: load_pc&jump -> abus; else immediate -> pc+1 mod 2^WIDTH; else hold. pc SHALL wrap from all-ones to 0.
REQ-021 A general-register write SHALL take effect at the edge; rd_a/rd_b SHALL show the new value only from the next cycle (no write-through bypass).
REQ-022 load_en with load_sel >= NREG SHALL be ignored; rd_*_sel >= NREG SHALL read 0.
REQ-023 qreg/q_valid: do_out=1 -> qreg<=dbus, q_valid<=1; do_out=0 & q_ack=1 -> q_valid<=0; otherwise hold.
REQ-024 do_out=1 while q_valid=1 and q_ack=0 SHALL overwrite qreg and set sticky q_overrun.
REQ-025 do_out=1 and q_ack=1 in the same cycle SHALL load qreg, keep q_valid=1, and not set q_overrun.
REQ-026 q_ack while q_valid=0 SHALL have no effect.
REQ-027 q_overrun SHALL clear only on reset.
REQ-028 assert_e=1 SHALL latch flag_carry<=carry; otherwise hold.
REQ-029 All register updates in one cycle SHALL be independent and simultaneous.

Reset
REQ-030 reset=1 at an edge SHALL set ir, pc, qreg, all general registers, q_valid, q_overrun, flag_carry, flag_zero to 0, overriding all other inputs that cycle.
REQ-031 Reset during a pending output (q_valid=1) SHALL drop the pending value; no ack is required.

Configuration
REQ-032 Macro REGISTER_BANK_ZERO_FLAG_EN defined: assert_e=1 SHALL also latch flag_zero<=(dbus==0).
REQ-033 Macro undefined: flag_zero port SHALL remain and be constant 0; all other behaviour unchanged.

Verification
REQ-034 Reset, then load_en=1, load_sel=2, dbus=8'hA5; next cycle rd_a_sel=2 -> rd_a=8'hA5; same-cycle read during write -> old value 0.
REQ-035 pc=8'hFF, immediate=1 -> pc=8'h00; load_pc=jump=immediate=1, abus=8'h40 -> pc=8'h40.
REQ-036 do_out with dbus=8'h11 -> q_valid=1, qreg=8'h11; do_out with 8'h22 and no ack -> qreg=8'h22, q_overrun=1; q_ack -> q_valid=0, q_overrun stays 1.
REQ-037 q_valid=1, do_out=1 and q_ack=1 with dbus=8'h33 -> qreg=8'h33, q_valid=1, q_overrun=0.
REQ-038 assert_e=1, carry=1, dbus=0 -> flag_carry=1; flag_zero=1 with REGISTER_BANK_ZERO_FLAG_EN, 0 without; reset asserted with load_ir=1 -> ir=0, all flags 0.
REQ-039 WIDTH=16, NREG=3: load_sel=3 write ignored, rd_a_sel=3 -> 0; pc 16'hFFFF + immediate -> 16'h0000.
